// File: rtl/signed_operand_entry.sv
// rtl/signed_operand_entry.sv - two-operand signed 4-bit entry FSM with debounced enter key
// Optional: define OVF_COUNT_EN to add the saturating ovf_count output.
module signed_operand_entry #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       key_n,
  output logic [3:0] input1,
  output logic [3:0] input2,
  output logic [3:0] sum,
  output logic       overflow,
  output logic [1:0] phase,
  output logic       result_valid
`ifdef OVF_COUNT_EN
  ,
  output logic [3:0] ovf_count
`endif
);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    RESULT  = 2'b10
  } state_e;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q;
  logic [DEB_W-1:0] cnt_q;
  logic             armed_q;
  logic             press_q;

  state_e     state_q, state_d;
  logic [3:0] input1_q, input1_d;
  logic [3:0] input2_q, input2_d;
  logic [3:0] sum_q, sum_d;
  logic       ovf_q, ovf_d;
  logic       valid_q, valid_d;

  // Synchronizer resets to "pressed" so a key held through reset never looks
  // like a fresh release; presses are armed only after a released level is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      press_q <= 1'b0;
      if (sync_q[1] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        deb_q   <= sync_q[1];
        cnt_q   <= '0;
        press_q <= armed_q & ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (sync_q[1] && deb_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    input1_d = input1_q;
    input2_d = input2_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    case (state_q)
      ENTER_A: begin
        input1_d = sw;
        input2_d = 4'd0;
        sum_d    = 4'd0;
        ovf_d    = 1'b0;
        valid_d  = 1'b0;
        if (press_q) state_d = ENTER_B;
      end
      ENTER_B: begin
        input2_d = sw;
        if (press_q) begin
          sum_d   = sw + input1_q;
          ovf_d   = (input1_q[3] == sw[3]) && (sum_d[3] != input1_q[3]);
          valid_d = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (press_q) begin
          input1_d = 4'd0;
          input2_d = 4'd0;
          sum_d    = 4'd0;
          ovf_d    = 1'b0;
          valid_d  = 1'b0;
          state_d  = ENTER_A;
        end
      end
      default: begin
        input1_d = 4'd0;
        input2_d = 4'd0;
        sum_d    = 4'd0;
        ovf_d    = 1'b0;
        valid_d  = 1'b0;
        state_d  = ENTER_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ENTER_A;
      input1_q <= 4'd0;
      input2_q <= 4'd0;
      sum_q    <= 4'd0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      input1_q <= input1_d;
      input2_q <= input2_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

`ifdef OVF_COUNT_EN
  logic [3:0] ovf_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= 4'd0;
    end else if (state_q == ENTER_B && press_q && ovf_d && ovf_count_q != 4'hf) begin
      ovf_count_q <= ovf_count_q + 4'd1;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

  assign input1       = input1_q;
  assign input2       = input2_q;
  assign sum          = sum_q;
  assign overflow     = ovf_q;
  assign phase        = state_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_signed_operand_entry.sv
// tb/tb_signed_operand_entry.sv - directed self-checking bench for signed_operand_entry
module tb_signed_operand_entry;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       key_n;
  logic [3:0] input1, input2, sum;
  logic       overflow;
  logic [1:0] phase;
  logic       result_valid;
`ifdef OVF_COUNT_EN
  logic [3:0] ovf_count;
`endif

  int checks = 0;
  int errors = 0;

  signed_operand_entry #(.DEB_CYCLES(4), .DEB_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .key_n(key_n),
    .input1(input1),
    .input2(input2),
    .sum(sum),
    .overflow(overflow),
    .phase(phase),
    .result_valid(result_valid)
`ifdef OVF_COUNT_EN
    ,
    .ovf_count(ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key();
    key_n = 1'b0;
    cycles(10);
    key_n = 1'b1;
    cycles(10);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 4'b0101;
    cycles(3);
    checks++;
    if (phase !== 2'b00) begin errors++; $display("FAIL reset_phase got %b exp 00", phase); end
    checks++;
    if ({input1, input2, sum, overflow, result_valid} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h %h %h %b %b exp all zero", input1, input2, sum, overflow, result_valid);
    end
`ifdef OVF_COUNT_EN
    checks++;
    if (ovf_count !== 4'd0) begin errors++; $display("FAIL reset_ovf_count got %0d exp 0", ovf_count); end
`endif
    rst_n = 1'b1;
    sw    = 4'b0000;
    cycles(12);
  endtask

  task automatic test_live_preview();
    sw = 4'b0110;
    cycles(2);
    checks++;
    if (input1 !== 4'b0110) begin errors++; $display("FAIL preview_input1 got %b exp 0110", input1); end
    checks++;
    if (input2 !== 4'b0000 || phase !== 2'b00) begin
      errors++;
      $display("FAIL preview_state got input2=%b phase=%b exp 0000/00", input2, phase);
    end
  endtask

  task automatic test_addition();
    logic [3:0] va [4] = '{4'b0011, 4'b0101, 4'b1000, 4'b1111};
    logic [3:0] vb [4] = '{4'b0100, 4'b0100, 4'b1111, 4'b0001};
    logic [3:0] vs [4] = '{4'b0111, 4'b1001, 4'b0111, 4'b0000};
    logic       vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] vc [4] = '{4'd0, 4'd1, 4'd2, 4'd2};
    for (int i = 0; i < 4; i++) begin
      sw = va[i];
      cycles(2);
      press_key();
      checks++;
      if (phase !== 2'b01 || input1 !== va[i]) begin
        errors++;
        $display("FAIL add%0d_capture_a got phase=%b input1=%b exp 01/%b", i, phase, input1, va[i]);
      end
      sw = vb[i];
      cycles(2);
      press_key();
      checks++;
      if (input1 !== va[i] || input2 !== vb[i]) begin
        errors++;
        $display("FAIL add%0d_operands got %b %b exp %b %b", i, input1, input2, va[i], vb[i]);
      end
      checks++;
      if (sum !== vs[i] || overflow !== vo[i]) begin
        errors++;
        $display("FAIL add%0d_sum got %b ovf %b exp %b ovf %b", i, sum, overflow, vs[i], vo[i]);
      end
      checks++;
      if (result_valid !== 1'b1 || phase !== 2'b10) begin
        errors++;
        $display("FAIL add%0d_result_state got valid=%b phase=%b exp 1/10", i, result_valid, phase);
      end
`ifdef OVF_COUNT_EN
      checks++;
      if (ovf_count !== vc[i]) begin errors++; $display("FAIL add%0d_ovf_count got %0d exp %0d", i, ovf_count, vc[i]); end
`else
      if (vc[i] > 4'd2) $display("unexpected table entry %0d", i);
`endif
      press_key();
      checks++;
      if (phase !== 2'b00) begin errors++; $display("FAIL add%0d_return got phase=%b exp 00", i, phase); end
    end
  endtask

  task automatic test_result_hold();
    sw = 4'b0010;
    cycles(2);
    press_key();
    sw = 4'b0011;
    cycles(2);
    press_key();
    for (int i = 0; i < 4; i++) begin
      sw = 4'(i * 5 + 3);
      cycles(3);
      checks++;
      if ({input1, input2, sum, overflow, result_valid, phase} !== {4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b1, 2'b10}) begin
        errors++;
        $display("FAIL hold%0d got %b %b %b %b %b %b exp 0010 0011 0101 0 1 10",
                 i, input1, input2, sum, overflow, result_valid, phase);
      end
    end
    sw = 4'b0000;
    press_key();
    checks++;
    if ({input1, input2, sum, overflow, result_valid, phase} !== 16'd0) begin
      errors++;
      $display("FAIL result_clear got %b %b %b %b %b %b exp all zero",
               input1, input2, sum, overflow, result_valid, phase);
    end
  endtask

  task automatic test_glitch();
    logic moved;
    moved = 1'b0;
    for (int g = 0; g < 5; g++) begin
      key_n = 1'b0;
      cycles(3);
      key_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
        cycles(1);
        if (phase !== 2'b00) moved = 1'b1;
      end
    end
    checks++;
    if (moved !== 1'b0) begin errors++; $display("FAIL glitch_ignored got moved=%b exp 0", moved); end
    moved = 1'b0;
    key_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycles(1);
      if (phase === 2'b10) moved = 1'b1;
    end
    key_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycles(1);
      if (phase === 2'b10) moved = 1'b1;
    end
    checks++;
    if (phase !== 2'b01 || moved !== 1'b0) begin
      errors++;
      $display("FAIL solid_press got phase=%b extra=%b exp 01/0", phase, moved);
    end
  endtask

  task automatic test_reset_held();
    logic moved;
    moved = 1'b0;
    key_n = 1'b0;
    cycles(2);
    checks++;
    if (phase !== 2'b01) begin errors++; $display("FAIL held_pre_reset got phase=%b exp 01", phase); end
    rst_n = 1'b0;
    cycles(3);
    checks++;
    if (phase !== 2'b00 || input1 !== 4'd0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL held_in_reset got phase=%b input1=%b valid=%b exp 00/0000/0", phase, input1, result_valid);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cycles(1);
      if (phase !== 2'b00) moved = 1'b1;
    end
    key_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cycles(1);
      if (phase !== 2'b00) moved = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) begin errors++; $display("FAIL held_no_press got moved=%b exp 0", moved); end
    press_key();
    checks++;
    if (phase !== 2'b01) begin errors++; $display("FAIL held_repress got phase=%b exp 01", phase); end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 4'd0;
    test_reset();
    test_live_preview();
    test_addition();
    test_result_hold();
    test_glitch();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
